// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared types and constants for the gate truth-table sequencer
//
// Contents:
//   seq_state_t      FSM state encoding (IDLE, APPLY, SETTLE, CHECK, DONE)
//   GATE_*           gate identifiers used on gate_sel
//   NVEC_*           number of vectors per gate, TOTAL_VEC per sweep
//   last_vec()       index of the final vector for a given gate

package gate_tt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    localparam logic [1:0] GATE_BUF  = 2'd0;
    localparam logic [1:0] GATE_XNOR = 2'd1;
    localparam logic [1:0] GATE_NAND = 2'd2;

    localparam int NVEC_BUF  = 2;
    localparam int NVEC_2IN  = 4;
    localparam int TOTAL_VEC = NVEC_BUF + 2 * NVEC_2IN;

    function automatic logic [1:0] last_vec(input logic [1:0] gate);
        if (gate == GATE_BUF) begin
            return 2'(NVEC_BUF - 1);
        end
        return 2'(NVEC_2IN - 1);
    endfunction

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// rtl/gate_tt_sequencer_if.sv - stimulus/response bus between sequencer and gate exercise block
//
// Signals:
//   x1          buf input
//   x2, y2      xnor inputs A/B
//   x3, y3      nand inputs A/B
//   z1, z2, z3  buf / xnor / nand outputs
// Modports:
//   master  sequencer side (drives x*, y*; reads z*)
//   slave   exercise block side (reads x*, y*; drives z*)

interface gate_tt_sequencer_if;

    logic x1;
    logic x2;
    logic y2;
    logic x3;
    logic y3;
    logic z1;
    logic z2;
    logic z3;

    modport master (
        output x1, x2, y2, x3, y3,
        input  z1, z2, z3
    );

    modport slave (
        input  x1, x2, y2, x3, y3,
        output z1, z2, z3
    );

endinterface

// File: rtl/gate_tt_ref_model.sv
// rtl/gate_tt_ref_model.sv - combinational expected-output model of the three exercised gates
//
// Ports:
//   gate_sel  in  2  gate id (GATE_BUF / GATE_XNOR / GATE_NAND)
//   x         in  1  first gate input (only input for buf)
//   y         in  1  second gate input (ignored for buf)
//   exp_z     out 1  expected gate output; 0 for an unused gate id

module gate_tt_ref_model
    import gate_tt_pkg::*;
(
    input  logic [1:0] gate_sel,
    input  logic       x,
    input  logic       y,
    output logic       exp_z
);

    always_comb begin
        exp_z = 1'b0;
        case (gate_sel)
            GATE_BUF:  exp_z = x;
            GATE_XNOR: exp_z = ~(x ^ y);
            GATE_NAND: exp_z = ~(x & y);
            default:   exp_z = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tt_sequencer.sv
// rtl/gate_tt_sequencer.sv - clocked exhaustive truth-table sweep of the buf/xnor/nand exercise block
//
// Parameters:
//   SETTLE_CYC  cycles between applying a vector and sampling (0 behaves as 1)
//   ERR_W       width of err_cnt
// Ports:
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous active-high reset
//   start         in   1      single-cycle sweep request, honoured only in IDLE
//   gio           master     stimulus x*/y* out, gate responses z* in
//   busy          out  1      sweep in progress (any state but IDLE)
//   gate_sel      out  2      gate under test
//   vec_idx       out  2      vector index within the gate
//   sample_valid  out  1      CHECK cycle marker
//   done          out  1      one-cycle end-of-sweep pulse
//   pass          out  1      no mismatches in the last completed sweep
//   err_cnt       out  ERR_W  saturating mismatch count

module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    gate_tt_sequencer_if.master  gio,
    output logic                 busy,
    output logic [1:0]           gate_sel,
    output logic [1:0]           vec_idx,
    output logic                 sample_valid,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    // The counter is loaded with SETTLE_EFF-1 and SETTLE exits on zero,
    // so SETTLE lasts exactly SETTLE_EFF cycles.
    localparam int CNT_W = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] settle_cnt;

    logic x1_q;
    logic x2_q;
    logic y2_q;
    logic x3_q;
    logic y3_q;

    logic cur_x;
    logic cur_y;
    logic cur_z;
    logic exp_z;
    logic mismatch;
    logic gate_last_vec;
    logic sweep_last_vec;

    assign gio.x1 = x1_q;
    assign gio.x2 = x2_q;
    assign gio.y2 = y2_q;
    assign gio.x3 = x3_q;
    assign gio.y3 = y3_q;

    // Route the inputs and output of the gate under test to the reference model.
    always_comb begin
        cur_x = 1'b0;
        cur_y = 1'b0;
        cur_z = 1'b0;
        case (gate_sel)
            GATE_BUF: begin
                cur_x = x1_q;
                cur_z = gio.z1;
            end
            GATE_XNOR: begin
                cur_x = x2_q;
                cur_y = y2_q;
                cur_z = gio.z2;
            end
            GATE_NAND: begin
                cur_x = x3_q;
                cur_y = y3_q;
                cur_z = gio.z3;
            end
            default: begin
                cur_x = 1'b0;
                cur_y = 1'b0;
                cur_z = 1'b0;
            end
        endcase
    end

    gate_tt_ref_model u_ref (
        .gate_sel (gate_sel),
        .x        (cur_x),
        .y        (cur_y),
        .exp_z    (exp_z)
    );

    assign mismatch       = (exp_z != cur_z);
    assign gate_last_vec  = (vec_idx == last_vec(gate_sel));
    assign sweep_last_vec = (gate_sel == GATE_NAND) && gate_last_vec;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_APPLY;
            ST_APPLY:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = sweep_last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy         = (state != ST_IDLE);
        sample_valid = (state == ST_CHECK);
        done         = (state == ST_DONE);
    end

    // Datapath: stimulus, vector position, settle counter, error tally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q       <= 1'b0;
            x2_q       <= 1'b0;
            y2_q       <= 1'b0;
            x3_q       <= 1'b0;
            y3_q       <= 1'b0;
            gate_sel   <= GATE_BUF;
            vec_idx    <= 2'd0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_cnt  <= '0;
                        pass     <= 1'b0;
                        gate_sel <= GATE_BUF;
                        vec_idx  <= 2'd0;
                    end
                end
                ST_APPLY: begin
                    // Only the gate under test sees a non-zero vector.
                    x1_q       <= (gate_sel == GATE_BUF)  ? vec_idx[0] : 1'b0;
                    x2_q       <= (gate_sel == GATE_XNOR) ? vec_idx[1] : 1'b0;
                    y2_q       <= (gate_sel == GATE_XNOR) ? vec_idx[0] : 1'b0;
                    x3_q       <= (gate_sel == GATE_NAND) ? vec_idx[1] : 1'b0;
                    y3_q       <= (gate_sel == GATE_NAND) ? vec_idx[0] : 1'b0;
                    settle_cnt <= CNT_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch && (err_cnt != ERR_MAX)) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (!sweep_last_vec) begin
                        if (gate_last_vec) begin
                            vec_idx  <= 2'd0;
                            gate_sel <= gate_sel + 2'd1;
                        end else begin
                            vec_idx  <= vec_idx + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // err_cnt already carries the final CHECK's update here.
                    pass     <= (err_cnt == '0);
                    x1_q     <= 1'b0;
                    x2_q     <= 1'b0;
                    y2_q     <= 1'b0;
                    x3_q     <= 1'b0;
                    y3_q     <= 1'b0;
                    gate_sel <= GATE_BUF;
                    vec_idx  <= 2'd0;
                end
                default: begin
                    settle_cnt <= '0;
                end
            endcase
        end
    end

endmodule
